// File: rtl/multicycle_control.sv
// Multi-cycle sequencing FSM for the RV32I core: steps fetch/decode/execute/memory/writeback
// and drives memory, IR, PC and register-file strobes. Optional PERF_COUNTERS_EN adds counters.
module multicycle_control #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [6:0]  opcode,
  input  logic        branch_cond,
  input  logic        mem_ready,
  output logic        mem_valid,
  output logic        mem_write,
  output logic        mem_is_data,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        illegal,
  output logic [2:0]  state
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
`endif
);

  localparam logic [2:0] FETCH     = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] EXECUTE   = 3'd2;
  localparam logic [2:0] MEMORY    = 3'd3;
  localparam logic [2:0] WRITEBACK = 3'd4;
  localparam logic [2:0] TRAP      = 3'd5;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  logic [2:0] next_state;
  logic       is_load;
  logic       is_store;
  logic       is_branch;
  logic       is_fence;
  logic       is_jump;
  logic       is_legal;

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_fence  = (opcode == OP_FENCE);
  assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);

  always_comb begin
    case (opcode)
      OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE: is_legal = 1'b1;
      default:                                      is_legal = 1'b0;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    next_state  = state;
    mem_valid   = 1'b0;
    mem_write   = 1'b0;
    mem_is_data = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    case (state)
      FETCH: begin
        mem_valid = 1'b1;
        // Gated so an active reset never strobes the IR even if memory answers.
        ir_write  = mem_ready & reset_n;
        if (mem_ready) next_state = DECODE;
      end
      DECODE: next_state = is_legal ? EXECUTE : TRAP;
      EXECUTE: begin
        if (is_load || is_store) begin
          next_state = MEMORY;
        end else if (is_branch || is_fence) begin
          pc_write   = 1'b1;
          pc_src     = is_branch & branch_cond;
          next_state = FETCH;
        end else begin
          next_state = WRITEBACK;
        end
      end
      MEMORY: begin
        mem_valid   = 1'b1;
        mem_is_data = 1'b1;
        mem_write   = is_store;
        if (mem_ready) begin
          pc_write   = is_store;
          next_state = is_store ? FETCH : WRITEBACK;
        end
      end
      WRITEBACK: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        pc_src     = is_jump;
        next_state = FETCH;
      end
      TRAP: begin
        illegal    = 1'b1;
        next_state = TRAP;
      end
      default: next_state = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RESET_STATE;
    else          state <= next_state;
  end

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (pc_write) instret_count <= instret_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table, randomized instructions against an
// instruction-level latency/strobe model, and hand-written reset/trap corner sequences.
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = 7'b0110011;
  logic       branch_cond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_valid, mem_write, mem_is_data, ir_write, pc_write, pc_src, reg_write, illegal;
  logic [2:0] state;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_count, instret_count;
`endif

  multicycle_control dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .branch_cond(branch_cond),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_is_data(mem_is_data), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .illegal(illegal), .state(state)
`ifdef PERF_COUNTERS_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  always #5 clock = ~clock;

  localparam logic [6:0] REG = 7'b0110011, IMM = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111, FENCE = 7'b0001111, SYSTEM = 7'b1110011;

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Instruction-level reference: latency is fetch + decode + execute plus the optional phases.
  function automatic int model_cycles(input logic [6:0] op, input int fw, input int mw);
    int n;
    n = (fw + 1) + 1 + 1;
    if (op == LD)                       n += (mw + 1) + 1;
    else if (op == ST)                  n += (mw + 1);
    else if (op != BR && op != FENCE)   n += 1;
    return n;
  endfunction

  function automatic logic model_rw(input logic [6:0] op);
    return !(op == ST || op == BR || op == FENCE);
  endfunction

  function automatic logic model_src(input logic [6:0] op, input logic bc);
    return (op == BR) ? bc : (op == JAL || op == JALR);
  endfunction

  task automatic run_instr(input string name, input logic [6:0] op, input logic bc,
                           input int fw, input int mw, input int exp_cyc,
                           input logic exp_rw, input logic exp_src);
    int seen[$];
    int want[$];
    int cyc = 0, irw = 0, pcw = 0, rw = 0, dc = 0, sc = 0, req_cnt = 0, diff = -1;
    logic src = 1'b0, stable = 1'b1, done;
    logic [1:0] fields = 2'b00;
    for (int i = 0; i <= fw; i++) want.push_back(0);
    want.push_back(1);
    want.push_back(2);
    if (op == LD || op == ST) for (int i = 0; i <= mw; i++) want.push_back(3);
    if (exp_rw) want.push_back(4);
    opcode = op;
    branch_cond = bc;
    for (int c = 0; c < 60; c++) begin
      if (mem_valid) mem_ready = (req_cnt == (mem_is_data ? mw : fw));
      else           mem_ready = 1'($urandom_range(0, 1));
      #4;
      seen.push_back(int'(state));
      cyc++;
      if (ir_write) irw++;
      if (reg_write) rw++;
      if (pc_write) begin pcw++; src = pc_src; end
      if (mem_valid && mem_is_data) dc++;
      if (mem_valid && mem_write) sc++;
      if (mem_valid) begin
        if (req_cnt == 0) fields = {mem_write, mem_is_data};
        else if (fields != {mem_write, mem_is_data}) stable = 1'b0;
        req_cnt = mem_ready ? 0 : req_cnt + 1;
      end
      done = pc_write || illegal;
      @(posedge clock);
      #1;
      if (done) break;
    end
    for (int i = 0; i < 64; i++) begin
      if (i >= seen.size() && i >= want.size()) break;
      if (i >= seen.size() || i >= want.size() || seen[i] != want[i]) begin diff = i; break; end
    end
    check({name, "_cycles"}, cyc, exp_cyc);
    check({name, "_state_seq_first_diff"}, diff, -1);
    check({name, "_ir_write_once"}, irw, 1);
    check({name, "_pc_write_once"}, pcw, 1);
    check({name, "_reg_write"}, rw, exp_rw ? 1 : 0);
    check({name, "_pc_src"}, src, exp_src);
    check({name, "_data_req_cycles"}, dc, (op == LD || op == ST) ? mw + 1 : 0);
    check({name, "_store_cycles"}, sc, (op == ST) ? mw + 1 : 0);
    check({name, "_req_stable"}, stable, 1'b1);
  endtask

  typedef struct {
    string      name;
    logic [6:0] op;
    logic       bc;
    int         fw;
    int         mw;
    int         cycles;
    logic       rw;
    logic       src;
  } vec_t;

  vec_t vecs[12];
  logic [6:0] legal_ops[10] = '{REG, IMM, LD, ST, BR, JAL, JALR, LUI, AUIPC, FENCE};

  initial begin
    vecs[0]  = '{"alu_reg",    REG,   1'b0, 0, 0, 4, 1'b1, 1'b0};
    vecs[1]  = '{"alu_imm",    IMM,   1'b0, 0, 0, 4, 1'b1, 1'b0};
    vecs[2]  = '{"load_wait2", LD,    1'b0, 0, 2, 7, 1'b1, 1'b0};
    vecs[3]  = '{"store_fw1",  ST,    1'b0, 1, 0, 5, 1'b0, 1'b0};
    vecs[4]  = '{"br_taken",   BR,    1'b1, 0, 0, 3, 1'b0, 1'b1};
    vecs[5]  = '{"br_not",     BR,    1'b0, 0, 0, 3, 1'b0, 1'b0};
    vecs[6]  = '{"fence",      FENCE, 1'b1, 0, 0, 3, 1'b0, 1'b0};
    vecs[7]  = '{"jal",        JAL,   1'b0, 0, 0, 4, 1'b1, 1'b1};
    vecs[8]  = '{"jalr_fw2",   JALR,  1'b0, 2, 0, 6, 1'b1, 1'b1};
    vecs[9]  = '{"lui",        LUI,   1'b0, 0, 0, 4, 1'b1, 1'b0};
    vecs[10] = '{"auipc",      AUIPC, 1'b1, 0, 3, 4, 1'b1, 1'b0};
    vecs[11] = '{"store_mw2",  ST,    1'b0, 0, 2, 6, 1'b0, 1'b0};

    // Reset with memory claiming ready: outputs must still be the idle fetch request.
    mem_ready = 1'b1;
    #12;
    check("reset_state", state, 3'd0);
    check("reset_outputs",
          {mem_valid, mem_write, mem_is_data, ir_write, pc_write, pc_src, reg_write, illegal},
          8'b1000_0000);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    foreach (vecs[i])
      run_instr(vecs[i].name, vecs[i].op, vecs[i].bc, vecs[i].fw, vecs[i].mw,
                vecs[i].cycles, vecs[i].rw, vecs[i].src);

    for (int n = 0; n < 40; n++) begin
      logic [6:0] op;
      logic bc;
      int fw, mw;
      op = legal_ops[$urandom_range(0, 9)];
      bc = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      run_instr($sformatf("rand%0d", n), op, bc, fw, mw,
                model_cycles(op, fw, mw), model_rw(op), model_src(op, bc));
    end

    // Illegal SYSTEM opcode: one fetch, one decode, then TRAP until reset.
    begin
      int bad = 0;
      opcode = SYSTEM;
      mem_ready = 1'b1;
      #4;
      check("trap_fetch_state", state, 3'd0);
      @(posedge clock); #1;
      #4;
      check("trap_decode_state", state, 3'd1);
      @(posedge clock); #1;
      for (int c = 0; c < 20; c++) begin
        mem_ready = 1'($urandom_range(0, 1));
        #4;
        if (!(state == 3'd5 && illegal && !mem_valid && !mem_write && !mem_is_data &&
              !ir_write && !pc_write && !pc_src && !reg_write)) bad++;
        @(posedge clock); #1;
      end
      check("trap_hold_bad_cycles", bad, 0);
      #2 reset_n = 1'b0;
      #1;
      check("trap_async_reset", {state, illegal, mem_valid}, {3'd0, 1'b0, 1'b1});
      @(posedge clock); #1;
      reset_n = 1'b1;
      mem_ready = 1'b0;
    end

    // Store abandoned mid-MEMORY by reset: request dropped, no retire.
    begin
      int pcw_seen = 0;
      opcode = ST;
      mem_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
        #4;
        if (pc_write) pcw_seen++;
        @(posedge clock); #1;
        mem_ready = 1'b0;
      end
      #4;
      check("store_in_memory", {state, mem_write, mem_valid, mem_is_data}, {3'd3, 3'b111});
      @(posedge clock); #1;
      #2 reset_n = 1'b0;
      #1;
      if (pc_write) pcw_seen++;
      check("store_reset_outputs", {state, mem_write, mem_is_data, mem_valid},
            {3'd0, 1'b0, 1'b0, 1'b1});
      check("store_reset_no_pc_write", pcw_seen, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      run_instr("after_reset_alu", REG, 1'b0, 0, 0, 4, 1'b1, 1'b0);
    end

`ifdef PERF_COUNTERS_EN
    reset_n = 1'b0;
    #1;
    check("perf_reset", {cycle_count, instret_count}, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int n = 0; n < 10; n++) run_instr($sformatf("perf_jal%0d", n), JAL, 1'b0, 0, 0, 4, 1'b1, 1'b1);
    check("perf_cycle_count", cycle_count, 32'd40);
    check("perf_instret_count", instret_count, 32'd10);
    force dut.cycle_count = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_count;
    @(posedge clock); #1;
    check("perf_cycle_wrap", cycle_count, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
